// File: rtl/bme280_i2c_slave_pkg.sv
// Shared types and constants for the BME280 I2C responder: FSM encoding,
// default device address and the sensor register map the reader touches.
`timescale 1ns/1ps
package bme280_i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ADDR_ACK,
    ST_REG_ADDR,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK
  } state_e;

  localparam logic [6:0] SLADDR_DEF    = 7'h76;

  localparam logic [7:0] REG_CHIP_ID   = 8'hD0;
  localparam logic [7:0] REG_CTRL_HUM  = 8'hF2;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_DATA      = 8'hF7;

endpackage

// File: rtl/bme280_i2c_slave_if.sv
// Pad and register-port bundle of the BME280 I2C responder; the slave modport
// is the responder's view, the master modport the pads plus register model.
`timescale 1ns/1ps
interface bme280_i2c_slave_if #(
  parameter int DWIDTH = 8
);
  logic              SclIn;
  logic              SdaIn;
  logic              SdaOut;
  logic              SdaOen;
  logic [DWIDTH-1:0] RegAddr;
  logic [DWIDTH-1:0] RegRdData;
  logic              RegRd;
  logic [DWIDTH-1:0] RegWrData;
  logic              RegWr;
  logic              Busy;
  logic              AddrHit;

  modport slave (
    input  SclIn, SdaIn, RegRdData,
    output SdaOut, SdaOen, RegAddr, RegRd, RegWrData, RegWr, Busy, AddrHit
  );

  modport master (
    output SclIn, SdaIn, RegRdData,
    input  SdaOut, SdaOen, RegAddr, RegRd, RegWrData, RegWr, Busy, AddrHit
  );
endinterface

// File: rtl/bme280_i2c_slave_bus_cond.sv
// SCL/SDA conditioning: 2-flop synchronizer, FILT-sample glitch filter per line,
// and edge / START / STOP detection on the filtered levels.
`timescale 1ns/1ps
module i2c_bus_cond #(
  parameter int FILT = 3
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  localparam int CW = $clog2(FILT + 1);

  // Lane 0 is SCL, lane 1 is SDA.
  logic [1:0]         s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         filt_q, filt_d, prev_q, prev_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = {sda_in, scl_in};
    s2_d   = s1_q;
    prev_d = filt_q;
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILT - 1)) filt_d[i] = s2_q[i];
        else                           cnt_d[i]  = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign scl      = filt_q[0];
  assign sda      = filt_q[1];
  assign scl_rise =  filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] &  prev_q[0];
  // SCL must have been high on both sides of the SDA transition.
  assign start    = prev_q[0] & filt_q[0] &  prev_q[1] & ~filt_q[1];
  assign stop     = prev_q[0] & filt_q[0] & ~prev_q[1] &  filt_q[1];

endmodule

// File: rtl/bme280_i2c_slave.sv
// I2C target that turns bus traffic into a byte register-access port so a
// register model can stand in for a BME280 (pointer write, write, burst read).
`timescale 1ns/1ps
module bme280_i2c_slave
  import bme280_i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLADDR = SLADDR_DEF,
  parameter int         DWIDTH = 8,
  parameter int         FILT   = 3
) (
  input logic               Clk,
  input logic               Rst_n,
  bme280_i2c_slave_if.slave bus
);
  logic scl, sda, scl_rise, scl_fall, start, stop;

  i2c_bus_cond #(.FILT(FILT)) u_cond (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .scl_in   (bus.SclIn),
    .sda_in   (bus.SdaIn),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d, tx_q, tx_d, rx_byte;
  logic [DWIDTH-1:0] reg_addr_q, reg_addr_d, reg_wr_data_q, reg_wr_data_d;
  logic              rw_q, rw_d, ack_phase_q, ack_phase_d, data_byte_q, data_byte_d;
  logic              sda_oen_q, sda_oen_d, inc_pend_q, inc_pend_d;
  logic              reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic              addr_hit_q, addr_hit_d, busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    rw_d          = rw_q;
    ack_phase_d   = ack_phase_q;
    data_byte_d   = data_byte_q;
    sda_oen_d     = sda_oen_q;
    reg_wr_data_d = reg_wr_data_q;
    reg_addr_d    = inc_pend_q ? reg_addr_q + DWIDTH'(1) : reg_addr_q;
    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    addr_hit_d    = 1'b0;
    inc_pend_d    = 1'b0;
    rx_byte       = {shift_q[DWIDTH-2:0], sda};

    if (stop) begin
      state_d   = ST_IDLE;
      sda_oen_d = 1'b1;
    end else if (start) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
      sda_oen_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_DEV_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == SLADDR) begin
              state_d     = ST_ADDR_ACK;
              rw_d        = rx_byte[0];
              ack_phase_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oen_d   = 1'b0;
            addr_hit_d  = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oen_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = rw_q ? ST_RD_LOAD : ST_REG_ADDR;
          end
        end
        ST_REG_ADDR, ST_WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_REG_ADDR) reg_addr_d    = rx_byte;
            else                        reg_wr_data_d = rx_byte;
            data_byte_d = (state_q == ST_WR_DATA);
            ack_phase_d = 1'b0;
            state_d     = ST_WR_ACK;
          end
        end
        // The pointer moves one cycle after the write strobe so RegWr pairs with the old address.
        ST_WR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oen_d   = 1'b0;
            ack_phase_d = 1'b1;
            reg_wr_d    = data_byte_q;
            inc_pend_d  = data_byte_q;
          end else begin
            sda_oen_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_WR_DATA;
          end
        end
        ST_RD_LOAD: begin
          tx_d       = bus.RegRdData;
          reg_rd_d   = 1'b1;
          inc_pend_d = 1'b1;
          sda_oen_d  = bus.RegRdData[DWIDTH-1];
          bit_cnt_d  = '0;
          state_d    = ST_RD_DATA;
        end
        ST_RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oen_d = 1'b1;
            state_d   = ST_RD_ACK;
          end else begin
            tx_d      = tx_q << 1;
            sda_oen_d = tx_q[DWIDTH-2];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda) state_d = ST_IDLE;
          else if (scl_fall)   state_d = ST_RD_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rw_q          <= 1'b0;
      ack_phase_q   <= 1'b0;
      data_byte_q   <= 1'b0;
      sda_oen_q     <= 1'b1;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      addr_hit_q    <= 1'b0;
      inc_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rw_q          <= rw_d;
      ack_phase_q   <= ack_phase_d;
      data_byte_q   <= data_byte_d;
      sda_oen_q     <= sda_oen_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      addr_hit_q    <= addr_hit_d;
      inc_pend_q    <= inc_pend_d;
      busy_q        <= busy_d;
    end
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  // The responder never holds SDA low while idle; a rising edge implies SCL high.
  assert property (@(posedge Clk) disable iff (!Rst_n) (state_q == ST_IDLE) |-> sda_oen_q);
  assert property (@(posedge Clk) disable iff (!Rst_n) scl_rise |-> scl);

  assign bus.SdaOut    = 1'b0;
  assign bus.SdaOen    = sda_oen_q;
  assign bus.RegAddr   = reg_addr_q;
  assign bus.RegWrData = reg_wr_data_q;
  assign bus.RegWr     = reg_wr_q;
  assign bus.RegRd     = reg_rd_q;
  assign bus.Busy      = busy_q;
  assign bus.AddrHit   = addr_hit_q;

endmodule

// File: tb/tb_bme280_i2c_slave.sv
// Directed bench for bme280_i2c_slave: bit-banged I2C master, open-drain SDA
// and a register model returning RegAddr ^ 0x5A.
`timescale 1ns/1ps
module tb_bme280_i2c_slave;
  import bme280_i2c_slave_pkg::*;

  localparam int Q = 100;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1, ovr = 1'b0;
  int nvec = 0, nerr = 0;
  int wr_cnt = 0, hit_cnt = 0;
  logic [7:0] wr_addr = '0, wr_data = '0;
  logic [7:0] rd_addr_q [$];

  bme280_i2c_slave_if #(.DWIDTH(8)) bus_if ();

  assign bus_if.SclIn     = scl_m;
  assign bus_if.SdaIn     = sda_m & (bus_if.SdaOen | ovr);
  assign bus_if.RegRdData = bus_if.RegAddr ^ 8'h5A;

  bme280_i2c_slave #(.SLADDR(SLADDR_DEF), .DWIDTH(8), .FILT(3)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_if)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus_if.RegWr) begin
      wr_cnt++;
      wr_addr = bus_if.RegAddr;
      wr_data = bus_if.RegWrData;
    end
    if (bus_if.RegRd) rd_addr_q.push_back(bus_if.RegAddr);
    if (bus_if.AddrHit) hit_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, want summary first");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #(2*Q); sda_m = 1'b0; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #(2*Q); sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic [7:0] gl1, input logic [7:0] gl2);
    for (int i = 7; i >= 0; i--) begin
      #Q; sda_m = b[i]; #Q; scl_m = 1'b1;
      if (gl1[i]) begin #Q; scl_m = 1'b0; #10; scl_m = 1'b1; #(Q-10); end
      else if (gl2[i]) begin #Q; scl_m = 1'b0; #20; scl_m = 1'b1; #(Q-20); end
      else #(2*Q);
      scl_m = 1'b0;
    end
  endtask

  task automatic get_ack(output logic a);
    #Q; sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; a = bus_if.SdaIn; #Q; scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8'h00, 8'h00);
    get_ack(a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(2*Q); scl_m = 1'b1; #Q; b[i] = bus_if.SdaIn; #Q; scl_m = 1'b0;
    end
    #Q; sda_m = nack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge Clk);
    #1;
    nvec++; if (bus_if.SdaOen !== 1'b1) begin nerr++; $display("FAIL rst_sdaoen: got %b want 1", bus_if.SdaOen); end
    nvec++; if (bus_if.SdaOut !== 1'b0) begin nerr++; $display("FAIL rst_sdaout: got %b want 0", bus_if.SdaOut); end
    nvec++; if (bus_if.RegAddr !== 8'h00) begin nerr++; $display("FAIL rst_regaddr: got %h want 00", bus_if.RegAddr); end
    nvec++; if (bus_if.RegWrData !== 8'h00) begin nerr++; $display("FAIL rst_wrdata: got %h want 00", bus_if.RegWrData); end
    nvec++; if ({bus_if.RegWr, bus_if.RegRd, bus_if.Busy, bus_if.AddrHit} !== 4'b0000) begin
      nerr++; $display("FAIL rst_strobes: got %b want 0000", {bus_if.RegWr, bus_if.RegRd, bus_if.Busy, bus_if.AddrHit});
    end
    @(negedge Clk); Rst_n = 1'b1;
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_reg_write();
    logic a0, a1, a2;
    int w0, h0;
    w0 = wr_cnt; h0 = hit_cnt;
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(REG_CTRL_MEAS, a1);
    write_byte(8'h27, a2);
    i2c_stop();
    nvec++; if ({a0, a1, a2} !== 3'b000) begin nerr++; $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
    nvec++; if (wr_cnt - w0 != 1) begin nerr++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
    nvec++; if (wr_addr !== 8'hF4) begin nerr++; $display("FAIL wr_addr: got %h want f4", wr_addr); end
    nvec++; if (wr_data !== 8'h27) begin nerr++; $display("FAIL wr_data: got %h want 27", wr_data); end
    nvec++; if (bus_if.RegAddr !== 8'hF5) begin nerr++; $display("FAIL wr_ptr_inc: got %h want f5", bus_if.RegAddr); end
    nvec++; if (hit_cnt - h0 != 1) begin nerr++; $display("FAIL wr_addrhit: got %0d want 1", hit_cnt - h0); end
    nvec++; if (bus_if.Busy !== 1'b0) begin nerr++; $display("FAIL wr_busy_end: got %b want 0", bus_if.Busy); end
  endtask

  task automatic test_burst_read();
    logic a;
    logic [7:0] got, ea;
    logic [7:0] exp_b [8];
    int r0;
    exp_b = '{8'hAD, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA6, 8'hA7, 8'hA4};
    r0 = rd_addr_q.size();
    i2c_start();
    write_byte(8'hEC, a);
    write_byte(REG_DATA, a);
    i2c_start();
    write_byte(8'hED, a);
    nvec++; if (a !== 1'b0) begin nerr++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    for (int i = 0; i < 8; i++) begin
      read_byte(i == 7, got);
      nvec++; if (got !== exp_b[i]) begin nerr++; $display("FAIL rd_byte%0d: got %h want %h", i, got, exp_b[i]); end
    end
    nvec++; if (bus_if.SdaOen !== 1'b1) begin nerr++; $display("FAIL rd_release_nack: got %b want 1", bus_if.SdaOen); end
    nvec++; if (rd_addr_q.size() - r0 != 8) begin nerr++; $display("FAIL rd_pulses: got %0d want 8", rd_addr_q.size() - r0); end
    for (int i = 0; i < 8 && r0 + i < rd_addr_q.size(); i++) begin
      ea = 8'(8'hF7 + i);
      nvec++; if (rd_addr_q[r0+i] !== ea) begin nerr++; $display("FAIL rd_strobe_addr%0d: got %h want %h", i, rd_addr_q[r0+i], ea); end
    end
    i2c_stop();
    nvec++; if (bus_if.Busy !== 1'b0) begin nerr++; $display("FAIL rd_idle_stop: got %b want 0", bus_if.Busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int w0, h0, r0;
    w0 = wr_cnt; h0 = hit_cnt; r0 = rd_addr_q.size();
    i2c_start();
    write_byte(8'hEE, a0);
    nvec++; if (a0 !== 1'b1) begin nerr++; $display("FAIL mm_nack: got %b want 1", a0); end
    nvec++; if (bus_if.Busy !== 1'b0) begin nerr++; $display("FAIL mm_busy: got %b want 0", bus_if.Busy); end
    write_byte(8'h55, a1);
    nvec++; if (a1 !== 1'b1) begin nerr++; $display("FAIL mm_data_nack: got %b want 1", a1); end
    i2c_stop();
    nvec++; if (hit_cnt - h0 + wr_cnt - w0 + rd_addr_q.size() - r0 != 0) begin
      nerr++; $display("FAIL mm_strobes: got hit=%0d wr=%0d rd=%0d want 0", hit_cnt - h0, wr_cnt - w0, rd_addr_q.size() - r0);
    end
  endtask

  task automatic test_pointer_wrap();
    logic a;
    logic [7:0] b0, b1;
    int r0;
    r0 = rd_addr_q.size();
    i2c_start();
    write_byte(8'hEC, a);
    write_byte(8'hFF, a);
    i2c_start();
    write_byte(8'hED, a);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    i2c_stop();
    nvec++; if ({b0, b1} !== 16'hA55A) begin nerr++; $display("FAIL wrap_bytes: got %h want a55a", {b0, b1}); end
    nvec++; if (rd_addr_q.size() - r0 != 2) begin nerr++; $display("FAIL wrap_pulses: got %0d want 2", rd_addr_q.size() - r0); end
    else begin
      nvec++; if ({rd_addr_q[r0], rd_addr_q[r0+1]} !== 16'hFF00) begin
        nerr++; $display("FAIL wrap_addr: got %h %h want ff 00", rd_addr_q[r0], rd_addr_q[r0+1]);
      end
    end
    nvec++; if (bus_if.RegAddr !== 8'h01) begin nerr++; $display("FAIL wrap_ptr: got %h want 01", bus_if.RegAddr); end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h10, a1);
    send_bits(8'h3C, 8'b0010_0000, 8'b0000_0100);
    get_ack(a2);
    i2c_stop();
    nvec++; if ({a0, a1, a2} !== 3'b000) begin nerr++; $display("FAIL gl_acks: got %b want 000", {a0, a1, a2}); end
    nvec++; if (wr_cnt - w0 != 1) begin nerr++; $display("FAIL gl_pulses: got %0d want 1", wr_cnt - w0); end
    nvec++; if ({wr_addr, wr_data} !== 16'h103C) begin nerr++; $display("FAIL gl_write: got %h %h want 10 3c", wr_addr, wr_data); end
    nvec++; if (bus_if.RegAddr !== 8'h11) begin nerr++; $display("FAIL gl_ptr: got %h want 11", bus_if.RegAddr); end
  endtask

  task automatic test_stop_abort();
    logic a;
    int lat;
    i2c_start();
    write_byte(8'hEC, a);
    write_byte(REG_DATA, a);
    i2c_start();
    write_byte(8'hED, a);
    sda_m = 1'b1; #(2*Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(2*Q);
    nvec++; if (bus_if.SdaOen !== 1'b0) begin nerr++; $display("FAIL ab_driving_low: got %b want 0", bus_if.SdaOen); end
    sda_m = 1'b0; #Q; scl_m = 1'b1; #(2*Q);
    ovr = 1'b1; sda_m = 1'b1;
    lat = 0;
    while (bus_if.SdaOen !== 1'b1 && lat < 12) begin
      @(posedge Clk); #1; lat++;
    end
    nvec++; if (bus_if.SdaOen !== 1'b1 || lat > 6) begin
      nerr++; $display("FAIL ab_release: got %0d cycles sdaoen=%b want <=6 and 1", lat, bus_if.SdaOen);
    end
    nvec++; if (bus_if.Busy !== 1'b0) begin nerr++; $display("FAIL ab_idle: got %b want 0", bus_if.Busy); end
    @(negedge Clk); ovr = 1'b0; #(2*Q);
  endtask

  task automatic test_reset_mid_ack();
    i2c_start();
    send_bits(8'hEC, 8'h00, 8'h00);
    #(2*Q);
    nvec++; if (bus_if.SdaOen !== 1'b0 || bus_if.RegAddr === 8'h00) begin
      nerr++; $display("FAIL rm_pre: got sdaoen=%b addr=%h want 0 and nonzero", bus_if.SdaOen, bus_if.RegAddr);
    end
    @(negedge Clk); Rst_n = 1'b0;
    @(posedge Clk); #1;
    nvec++; if (bus_if.SdaOen !== 1'b1) begin nerr++; $display("FAIL rm_sdaoen: got %b want 1", bus_if.SdaOen); end
    nvec++; if ({bus_if.RegAddr, bus_if.RegWrData} !== 16'h0000) begin
      nerr++; $display("FAIL rm_regs: got %h %h want 00 00", bus_if.RegAddr, bus_if.RegWrData);
    end
    nvec++; if ({bus_if.RegWr, bus_if.RegRd, bus_if.Busy, bus_if.AddrHit} !== 4'b0000) begin
      nerr++; $display("FAIL rm_strobes: got %b want 0000", {bus_if.RegWr, bus_if.RegRd, bus_if.Busy, bus_if.AddrHit});
    end
    @(negedge Clk); Rst_n = 1'b1;
    sda_m = 1'b1; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    i2c_stop();
    nvec++; if (bus_if.Busy !== 1'b0 || bus_if.RegAddr !== 8'h00) begin
      nerr++; $display("FAIL rm_after: got busy=%b addr=%h want 0 00", bus_if.Busy, bus_if.RegAddr);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_burst_read();
    test_addr_mismatch();
    test_pointer_wrap();
    test_glitch();
    test_stop_abort();
    test_reset_mid_ack();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
